// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encodings and default frame sizing,
// common to the receiver and the transmitter of the debug unit.
package uart_pkg;

  localparam int DBIT_DEF     = 8;   // data bits per frame
  localparam int SB_TICK_DEF  = 16;  // oversampling ticks per bit
  localparam int NB_STATE_DEF = 5;   // one-hot state register width

  // One-hot state encodings (PARITY is reserved even when parity is off)
  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// selectable reset value so an idle-high line reads idle out of reset.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// UART receiver: oversamples the serial line with the shared baud tick,
// rebuilds one LSB-first frame and presents the byte with a one-cycle done
// pulse plus error flags. Optional even-parity support is compiled in with
// the UART_RX_PARITY_EN macro (adds the PARITY state and o_parity_err).
module rx_uart
  import uart_pkg::*;
#(
  parameter int DBIT     = DBIT_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int NB_STATE = NB_STATE_DEF
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done_tick,
  output logic            o_frame_err
`ifdef UART_RX_PARITY_EN
  ,output logic           o_parity_err
`endif
);

  typedef enum logic [NB_STATE-1:0] {
    S_IDLE   = NB_STATE'(ST_IDLE),
    S_START  = NB_STATE'(ST_START),
    S_DATA   = NB_STATE'(ST_DATA),
    S_PARITY = NB_STATE'(ST_PARITY),
    S_STOP   = NB_STATE'(ST_STOP)
  } state_t;

  localparam logic [3:0] TICK_MID  = 4'(SB_TICK / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(SB_TICK - 1);
  localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

  state_t          state, state_next;
  logic [3:0]      tick_cnt, tick_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] shreg, shreg_next;
  logic            armed, armed_next;
  logic [DBIT-1:0] data_next;
  logic            ferr_next;
  logic            done_next;
  logic            rx_s;

`ifdef UART_RX_PARITY_EN
  logic perr, perr_next;
  logic perr_out_next;

  // Even parity: a mismatch when the parity bit disagrees with the data XOR
  function automatic logic even_parity_err(input logic par_bit,
                                           input logic [DBIT-1:0] bits);
    return par_bit ^ (^bits);
  endfunction
`endif

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // State, counters, shift register and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_IDLE;
      tick_cnt       <= 4'd0;
      n              <= 3'd0;
      shreg          <= '0;
      armed          <= 1'b1;
      o_data         <= '0;
      o_frame_err    <= 1'b0;
      o_rx_done_tick <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr           <= 1'b0;
      o_parity_err   <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      tick_cnt       <= tick_next;
      n              <= n_next;
      shreg          <= shreg_next;
      armed          <= armed_next;
      o_data         <= data_next;
      o_frame_err    <= ferr_next;
      o_rx_done_tick <= done_next;
`ifdef UART_RX_PARITY_EN
      perr           <= perr_next;
      o_parity_err   <= perr_out_next;
`endif
    end
  end

  // Next-state and datapath decisions, taken only on tick cycles
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    n_next     = n;
    shreg_next = shreg;
    armed_next = armed;
    data_next  = o_data;
    ferr_next  = o_frame_err;
    done_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next     = perr;
    perr_out_next = o_parity_err;
`endif

    case (state)
      S_IDLE: begin
        if (rx_s) begin
          armed_next = 1'b1;
        end else if (armed) begin
          state_next = S_START;
          tick_next  = 4'd0;
        end else begin
          // Line still low after a break: wait for it to return high
          state_next = S_IDLE;
        end
      end

      S_START: begin
        if (i_s_tick) begin
          if (tick_cnt == TICK_MID) begin
            if (!rx_s) begin
              state_next = S_DATA;
              tick_next  = 4'd0;
              n_next     = 3'd0;
            end else begin
              // Low pulse shorter than half a bit: treat as a glitch
              state_next = S_IDLE;
              tick_next  = 4'd0;
            end
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end else begin
          tick_next = tick_cnt;
        end
      end

      S_DATA: begin
        if (i_s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            shreg_next = {rx_s, shreg[DBIT-1:1]};
            tick_next  = 4'd0;
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = S_PARITY;
`else
              state_next = S_STOP;
`endif
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end else begin
          tick_next = tick_cnt;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            perr_next  = even_parity_err(rx_s, shreg);
            tick_next  = 4'd0;
            state_next = S_STOP;
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end else begin
          tick_next = tick_cnt;
        end
      end
`endif

      S_STOP: begin
        if (i_s_tick) begin
          if (tick_cnt == TICK_LAST) begin
            data_next  = shreg;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
            tick_next  = 4'd0;
            state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            perr_out_next = perr;
`endif
            if (!rx_s) begin
              // Break: deliver this frame once, then ignore the low line
              armed_next = 1'b0;
            end else begin
              armed_next = armed;
            end
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end else begin
          tick_next = tick_cnt;
        end
      end

      default: begin
        state_next = S_IDLE;
        tick_next  = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: a table of frames plus hand-written
// sequences for latency, glitches, break, and mid-frame reset. Expected
// results are queued when a frame is sent and popped when the DUT pulses.
`timescale 1ns/1ps
module tb_rx_uart;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_s_tick;
  logic [7:0] o_data;
  logic       o_rx_done_tick;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  rx_uart dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_rx           (i_rx),
    .i_s_tick       (i_s_tick),
    .o_data         (o_data),
    .o_rx_done_tick (o_rx_done_tick),
    .o_frame_err    (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,.o_parity_err  (o_parity_err)
`endif
  );

  initial forever #5 i_clock = ~i_clock;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         tg;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   cycle      = 0;
  int   pulses     = 0;
  int   last_pulse = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // One clock; outputs sampled 1ns after the edge and matched to the scoreboard
  task automatic clk1();
    exp_t e;
    @(posedge i_clock);
    cycle++;
    #1;
    if (o_rx_done_tick === 1'b1) begin
      pulses++;
      last_pulse = cycle;
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data", 32'(o_data), 32'(e.data));
        check("frame_err", 32'(o_frame_err), 32'(e.ferr));
`ifdef UART_RX_PARITY_EN
        check("parity_err", 32'(o_parity_err), 32'(e.perr));
`endif
      end
    end
  endtask

  task automatic do_tick(input int tg);
    i_s_tick = 1'b1;
    clk1();
    i_s_tick = 1'b0;
    repeat (tg - 1) clk1();
  endtask

  task automatic send_bit(input logic b, input int tg);
    i_rx = b;
    repeat (16) do_tick(tg);
  endtask

  task automatic idle(input int ticks, input int tg);
    i_rx = 1'b1;
    repeat (ticks) do_tick(tg);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int tg);
    send_bit(1'b0, tg);
    for (int i = 0; i < 8; i++) send_bit(d[i], tg);
`ifdef UART_RX_PARITY_EN
    send_bit(par, tg);
`else
    if (par === 1'bx) i_rx = 1'b0;   // parity bit not transmitted in this build
    else i_rx = 1'b0;
`endif
    send_bit(stop, tg);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic ferr, input logic perr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    e.perr = perr;
    exp_q.push_back(e);
  endtask

  vec_t vecs[8];
  int   p0;
  int   c0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 2,  2, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0,  2, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 0,  2, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 5,  1, 8'h3C, 1'b0};
    vecs[4] = '{8'h5A, 1'b1, 0,  1, 8'h5A, 1'b0};
    vecs[5] = '{8'hC3, 1'b0, 3,  2, 8'hC3, 1'b1};
    vecs[6] = '{8'h81, 1'b1, 10, 2, 8'h81, 1'b0};
    vecs[7] = '{8'h7E, 1'b1, 0,  3, 8'h7E, 1'b0};

    i_reset  = 1'b1;
    i_rx     = 1'b1;
    i_s_tick = 1'b0;
    repeat (3) clk1();
    check("rst_data", 32'(o_data), 32'h0);
    check("rst_done", 32'(o_rx_done_tick), 32'h0);
    check("rst_ferr", 32'(o_frame_err), 32'h0);
    i_reset = 1'b0;
    repeat (2) clk1();

    // Latency: start seen 2 sync + 1 detect cycles late, stop sampled at DUT tick 152
    idle(4, 2);
    expect_frame(8'hA5, 1'b0, 1'b0);
    p0 = pulses;
    c0 = cycle;
    send_frame(8'hA5, 1'b1, ^8'hA5, 2);
    idle(4, 2);
    check("latency_cycles", 32'(last_pulse - c0), 32'd307);
    check("latency_pulses", 32'(pulses - p0), 32'd1);

    // Table of frames, mostly back-to-back, with assorted tick spacings
    p0 = pulses;
    for (int i = 0; i < 8; i++) begin
      idle(vecs[i].gap, vecs[i].tg);
      expect_frame(vecs[i].exp_data, vecs[i].exp_ferr, 1'b0);
      send_frame(vecs[i].data, vecs[i].stop, ^vecs[i].data, vecs[i].tg);
    end
    idle(20, 2);
    check("table_pulses", 32'(pulses - p0), 32'd8);
    check("table_q_empty", 32'(exp_q.size()), 32'd0);

    // Short low glitches (4 and 7 ticks) are rejected, then a frame is received
    for (int g = 4; g <= 7; g += 3) begin
      idle(10, 2);
      p0 = pulses;
      i_rx = 1'b0;
      repeat (g) do_tick(2);
      idle(30, 2);
      check("glitch_no_pulse", 32'(pulses - p0), 32'd0);
    end
    expect_frame(8'h3C, 1'b0, 1'b0);
    p0 = pulses;
    send_frame(8'h3C, 1'b1, ^8'h3C, 2);
    idle(20, 2);
    check("post_glitch_pulses", 32'(pulses - p0), 32'd1);

    // Break: stop bit low, line held low for three frame times
    idle(10, 2);
    expect_frame(8'h55, 1'b1, 1'b0);
    p0 = pulses;
    send_frame(8'h55, 1'b0, ^8'h55, 2);
    i_rx = 1'b0;
    repeat (480) do_tick(2);
    check("break_one_pulse", 32'(pulses - p0), 32'd1);
    idle(20, 2);
    check("break_release_no_pulse", 32'(pulses - p0), 32'd1);
    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, ^8'hA5, 2);
    idle(20, 2);
    check("break_recover_pulses", 32'(pulses - p0), 32'd2);

    // Reset in the middle of data bit 4 aborts the frame
    idle(10, 2);
    p0 = pulses;
    send_bit(1'b0, 2);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 2);
    i_rx = 1'b0;
    repeat (8) do_tick(2);
    i_reset = 1'b1;
    i_rx    = 1'b1;
    #1;
    check("midrst_data", 32'(o_data), 32'h0);
    check("midrst_done", 32'(o_rx_done_tick), 32'h0);
    check("midrst_ferr", 32'(o_frame_err), 32'h0);
    repeat (3) clk1();
    i_reset = 1'b0;
    idle(20, 2);
    check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
    expect_frame(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, ^8'h81, 2);
    idle(20, 2);
    check("midrst_recover_pulses", 32'(pulses - p0), 32'd1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has odd weight, so parity bit 1 is correct
    p0 = pulses;
    expect_frame(8'h07, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 2);
    idle(10, 2);
    expect_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0, 2);
    idle(20, 2);
    check("parity_pulses", 32'(pulses - p0), 32'd2);
`endif

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
